// File: rtl/hex_digit_entry_encoder_if.sv
// Keypad-to-operand bus: debounced key/control levels in, entered operand and status out.
// Level inputs carry no handshake; the encoder never backpressures the keypad.
interface hex_digit_entry_encoder_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       key_code;
    logic             key_strobe;
    logic             backspace;
    logic             clear;
    logic             commit;
    logic [WIDTH-1:0] binary_number;
    logic [3:0]       digit_count;
    logic             entry_active;
    logic             number_valid;
    logic             overflow;

    modport master (
        output key_code, key_strobe, backspace, clear, commit,
        input  binary_number, digit_count, entry_active, number_valid, overflow
    );

    modport slave (
        input  key_code, key_strobe, backspace, clear, commit,
        output binary_number, digit_count, entry_active, number_valid, overflow
    );
endinterface

// File: rtl/hex_digit_entry_encoder.sv
// Builds a hex operand from MSD-first keypresses with backspace/clear/commit; 1-cycle latency
// from the sampling edge, no backpressure (coincident lower-priority events are dropped).
module hex_digit_entry_encoder #(
    parameter int MAX_DIGITS = 8,
    parameter int WIDTH      = 4 * MAX_DIGITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    hex_digit_entry_encoder_if.slave     bus
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ENTRY     = 2'd1,
        FULL      = 2'd2,
        COMMITTED = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT     = 4'(MAX_DIGITS);
    localparam state_t     FIRST_STATE = (MAX_DIGITS == 1) ? FULL : ENTRY;

    state_t           state;
    logic [WIDTH-1:0] value;
    logic [3:0]       count;
    logic             ovf;
    logic             valid;

    // armed stays low for the first clocked cycle after reset so that levels
    // already high at reset release only load history and never fire an event
    logic             armed;
    logic             hist_key;
    logic             hist_bs;
    logic             hist_clr;
    logic             hist_cmt;

    logic             ev_key;
    logic             ev_bs;
    logic             ev_clr;
    logic             ev_cmt;
    logic [WIDTH+3:0] shifted;
    logic [WIDTH-1:0] shr;
    logic [3:0]       count_inc;

    assign ev_key    = armed & bus.key_strobe & ~hist_key;
    assign ev_bs     = armed & bus.backspace  & ~hist_bs;
    assign ev_clr    = armed & bus.clear      & ~hist_clr;
    assign ev_cmt    = armed & bus.commit     & ~hist_cmt;

    assign shifted   = {value, bus.key_code};
    assign shr       = value >> 4;
    assign count_inc = count + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            value    <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
            armed    <= 1'b0;
            hist_key <= 1'b0;
            hist_bs  <= 1'b0;
            hist_clr <= 1'b0;
            hist_cmt <= 1'b0;
        end else begin
            armed    <= 1'b1;
            hist_key <= bus.key_strobe;
            hist_bs  <= bus.backspace;
            hist_clr <= bus.clear;
            hist_cmt <= bus.commit;
            valid    <= 1'b0;

            if (ev_clr) begin
                value <= '0;
                count <= '0;
                ovf   <= 1'b0;
                state <= EMPTY;
            end else if (ev_cmt) begin
                if (state != COMMITTED) begin
                    state <= COMMITTED;
                    valid <= 1'b1;
                end
            end else if (ev_bs) begin
                if (state == ENTRY || state == FULL) begin
                    value <= shr;
                    ovf   <= 1'b0;
                    if (shr == '0) begin
                        count <= '0;
                        state <= EMPTY;
                    end else begin
                        count <= count - 4'd1;
                        state <= ENTRY;
                    end
                end
            end else if (ev_key) begin
                case (state)
                    EMPTY, COMMITTED: begin
                        // a keypress after commit starts a fresh operand
                        if (state == COMMITTED) begin
                            ovf <= 1'b0;
                        end
                        if (bus.key_code != 4'd0) begin
                            value <= WIDTH'(bus.key_code);
                            count <= 4'd1;
                            state <= FIRST_STATE;
                        end else begin
                            value <= '0;
                            count <= '0;
                            state <= EMPTY;
                        end
                    end
                    ENTRY: begin
                        value <= shifted[WIDTH-1:0];
                        count <= count_inc;
                        state <= (count_inc == MAX_CNT) ? FULL : ENTRY;
                    end
                    FULL: begin
                        ovf <= 1'b1;
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.binary_number = value;
    assign bus.digit_count   = count;
    assign bus.entry_active  = (state == ENTRY) || (state == FULL);
    assign bus.number_valid  = valid;
    assign bus.overflow      = ovf;

endmodule

// File: tb/tb_hex_digit_entry_encoder.sv
// Directed bench for hex_digit_entry_encoder: a digit-list model checked every cycle,
// plus literal expectations for each scenario.
module tb_hex_digit_entry_encoder;

    localparam int MAXD = 8;
    localparam int W    = 4 * MAXD;

    logic clk = 1'b0;
    logic reset_n;

    hex_digit_entry_encoder_if #(.WIDTH(W)) bus ();

    hex_digit_entry_encoder #(.MAX_DIGITS(MAXD), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the entered operand as a list of significant digits, MSD first.
    int digits[$];
    bit m_committed, m_ovf, m_valid, m_armed;
    bit h_k, h_b, h_c, h_m;

    function automatic logic [31:0] model_value();
        logic [31:0] v = 0;
        foreach (digits[i]) v = v * 16 + 32'(digits[i]);
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit e_k, e_b, e_c, e_m;
        if (!reset_n) begin
            digits.delete();
            m_committed = 0; m_ovf = 0; m_valid = 0; m_armed = 0;
            h_k = 0; h_b = 0; h_c = 0; h_m = 0;
        end else begin
            e_k = m_armed && bus.key_strobe && !h_k;
            e_b = m_armed && bus.backspace  && !h_b;
            e_c = m_armed && bus.clear      && !h_c;
            e_m = m_armed && bus.commit     && !h_m;
            m_armed = 1;
            h_k = bus.key_strobe; h_b = bus.backspace; h_c = bus.clear; h_m = bus.commit;
            m_valid = 0;
            if (e_c) begin
                digits.delete(); m_committed = 0; m_ovf = 0;
            end else if (e_m) begin
                if (!m_committed) begin m_committed = 1; m_valid = 1; end
            end else if (e_b) begin
                if (!m_committed && digits.size() > 0) begin
                    void'(digits.pop_back());
                    m_ovf = 0;
                end
            end else if (e_k) begin
                if (m_committed) begin digits.delete(); m_committed = 0; m_ovf = 0; end
                if (digits.size() == MAXD) m_ovf = 1;
                else if (digits.size() > 0 || bus.key_code != 0) digits.push_back(int'(bus.key_code));
            end
        end
    end

    always @(posedge clk) begin
        #2;
        check("cyc_value",  bus.binary_number,        model_value());
        check("cyc_count",  32'(bus.digit_count),     32'(digits.size()));
        check("cyc_active", 32'(bus.entry_active),    32'(!m_committed && digits.size() > 0));
        check("cyc_valid",  32'(bus.number_valid),    32'(m_valid));
        check("cyc_ovf",    32'(bus.overflow),        32'(m_ovf));
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk); bus.key_code = k; bus.key_strobe = 1'b1;
        @(negedge clk); bus.key_strobe = 1'b0;
    endtask

    // which: 0=backspace 1=clear 2=commit
    task automatic ctrl(input int which);
        @(negedge clk);
        case (which)
            0: bus.backspace = 1'b1;
            1: bus.clear     = 1'b1;
            default: bus.commit = 1'b1;
        endcase
        @(negedge clk);
        bus.backspace = 1'b0; bus.clear = 1'b0; bus.commit = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [31:0] val, input int cnt,
                              input bit act, input bit vld, input bit ovf);
        check({name, "_value"},  bus.binary_number,     val);
        check({name, "_count"},  32'(bus.digit_count),  32'(cnt));
        check({name, "_active"}, 32'(bus.entry_active), 32'(act));
        check({name, "_valid"},  32'(bus.number_valid), 32'(vld));
        check({name, "_ovf"},    32'(bus.overflow),     32'(ovf));
    endtask

    initial begin
        reset_n = 1'b0;
        bus.key_code = 4'd0; bus.key_strobe = 1'b0;
        bus.backspace = 1'b0; bus.clear = 1'b0; bus.commit = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("reset", 32'h0, 0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0,0,A,3,F then commit
        press(4'h0); press(4'h0);
        check_outs("lead_zero", 32'h0, 0, 0, 0, 0);
        press(4'hA); press(4'h3); press(4'hF);
        check_outs("a3f", 32'h00000A3F, 3, 1, 0, 0);
        ctrl(2);
        check_outs("commit", 32'h00000A3F, 3, 0, 1, 0);
        @(negedge clk);
        check_outs("commit_after", 32'h00000A3F, 3, 0, 0, 0);
        ctrl(2);
        check_outs("recommit", 32'h00000A3F, 3, 0, 0, 0);

        // fill to 8 digits, overflow, backspace
        ctrl(1);
        for (int i = 1; i <= 8; i++) press(4'(i));
        check_outs("full", 32'h12345678, 8, 1, 0, 0);
        press(4'h9);
        check_outs("overflow", 32'h12345678, 8, 1, 0, 1);
        ctrl(0);
        check_outs("bs_full", 32'h01234567, 7, 1, 0, 0);

        // backspace down to empty, extra backspace ignored
        ctrl(1);
        press(4'h5);
        ctrl(0);
        check_outs("bs_empty", 32'h0, 0, 0, 0, 0);
        ctrl(0);
        check_outs("bs_extra", 32'h0, 0, 0, 0, 0);

        // held key produces one digit
        @(negedge clk); bus.key_code = 4'h7; bus.key_strobe = 1'b1;
        repeat (20) @(negedge clk);
        bus.key_strobe = 1'b0;
        check_outs("held", 32'h7, 1, 1, 0, 0);

        // clear beats commit and digit in the same cycle
        ctrl(1);
        press(4'hB); press(4'hE); press(4'hE); press(4'hF);
        check_outs("beef", 32'h0000BEEF, 4, 1, 0, 0);
        @(negedge clk);
        bus.clear = 1'b1; bus.commit = 1'b1; bus.key_code = 4'h1; bus.key_strobe = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.commit = 1'b0; bus.key_strobe = 1'b0;
        check_outs("prio", 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        check_outs("prio_after", 32'h0, 0, 0, 0, 0);

        // new entry after commit, then async reset mid-cycle
        press(4'h4); press(4'h2);
        ctrl(2);
        check_outs("commit42", 32'h42, 2, 0, 1, 0);
        press(4'hC);
        check_outs("new_entry", 32'hC, 1, 1, 0, 0);
        @(posedge clk); #3;
        bus.key_code = 4'h5; bus.key_strobe = 1'b1;
        reset_n = 1'b0;
        #1;
        check_outs("async_rst", 32'h0, 0, 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("held_rst", 32'h0, 0, 0, 0, 0);
        bus.key_strobe = 1'b0;
        press(4'h5);
        check_outs("post_rst", 32'h5, 1, 1, 0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
